// File: rtl/tree_stage_reg_pkg.sv
// Shared definitions for the classification-tree pipeline: stage state encoding
// and the default per-lane field widths used by the tree node stages.
package tree_pipe_pkg;

  localparam int PACKET_WIDTH_DEF = 104;
  localparam int NODE_WIDTH_DEF   = 40;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_TWO   = ST_TWO
  } stage_state_e;

endpackage

// File: rtl/tree_stage_reg_if.sv
// Bundle handshake between two tree levels plus the stage's flush and counter controls.
// The stage itself takes the slave view; the upstream/downstream side takes master.
interface tree_stage_reg_if
  import tree_pipe_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter int NODE_WIDTH   = NODE_WIDTH_DEF,
  parameter int COUNT_WIDTH  = 32
);
  logic [LANES*PACKET_WIDTH-1:0] packet_in;
  logic [LANES*NODE_WIDTH-1:0]   node_in;
  logic [LANES-1:0]              matched_in;
  logic [LANES-1:0]              data_valid_in;
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES*PACKET_WIDTH-1:0] packet_out;
  logic [LANES*NODE_WIDTH-1:0]   node_out;
  logic [LANES-1:0]              matched_out;
  logic [LANES-1:0]              data_valid_out;
  logic                          out_valid;
  logic                          out_ready;
  logic                          flush;
  logic                          clr_count;
  logic [COUNT_WIDTH-1:0]        match_count;

  modport master (
    output packet_in, node_in, matched_in, data_valid_in, in_valid, out_ready, flush, clr_count,
    input  in_ready, packet_out, node_out, matched_out, data_valid_out, out_valid, match_count
  );

  modport slave (
    input  packet_in, node_in, matched_in, data_valid_in, in_valid, out_ready, flush, clr_count,
    output in_ready, packet_out, node_out, matched_out, data_valid_out, out_valid, match_count
  );
endinterface

// File: rtl/tree_stage_reg_popcount.sv
// Counts set bits across the lanes of a bundle.
module tree_match_popcount #(
  parameter int LANES = 2,
  parameter int CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] bits_i,
  output logic [CW-1:0]    count_o
);

  // Ripple sum over lanes
  always_comb begin
    count_o = '0;
    for (int i = 0; i < LANES; i++) begin
      count_o = count_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/tree_stage_reg.sv
// Elastic two-entry stage register between tree levels: main register drives the
// outputs, a skid register absorbs one extra bundle during a downstream stall.
module tree_stage_reg
  import tree_pipe_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter int NODE_WIDTH   = NODE_WIDTH_DEF,
  parameter int COUNT_WIDTH  = 32
) (
  input logic             clk,
  input logic             RSTn,
  tree_stage_reg_if.slave bus
);

  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = ((COUNT_WIDTH > PC_W) ? COUNT_WIDTH : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({COUNT_WIDTH{1'b1}});

  typedef struct packed {
    logic [LANES*PACKET_WIDTH-1:0] packet;
    logic [LANES*NODE_WIDTH-1:0]   node;
    logic [LANES-1:0]              matched;
    logic [LANES-1:0]              dvalid;
  } bundle_t;

  stage_state_e           state_q;
  bundle_t                main_q;
  bundle_t                skid_q;
  bundle_t                in_s;
  logic                   in_ready_s;
  logic                   out_valid_s;
  logic                   in_fire_s;
  logic                   out_fire_s;
  logic [LANES-1:0]       dv_out_s;
  logic [PC_W-1:0]        pop_s;
  logic [SUM_W-1:0]       sum_s;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  assign in_s = '{packet: bus.packet_in, node: bus.node_in,
                  matched: bus.matched_in, dvalid: bus.data_valid_in};

  // Handshake flags decode straight from the state register, so no input reaches an output
  assign in_ready_s  = (state_q != S_TWO);
  assign out_valid_s = (state_q != S_EMPTY);
  assign in_fire_s   = bus.in_valid & in_ready_s;
  assign out_fire_s  = out_valid_s & bus.out_ready;
  assign dv_out_s    = main_q.dvalid & {LANES{out_valid_s}};

  // Occupancy FSM with main/skid storage; flush discards everything including this cycle's input
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (bus.flush) begin
      state_q <= S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire_s) begin
            main_q  <= in_s;
            state_q <= S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire_s && !out_fire_s) begin
            skid_q  <= in_s;
            state_q <= S_TWO;
          end else if (in_fire_s) begin
            main_q <= in_s;
          end else if (out_fire_s) begin
            state_q <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire_s) begin
            main_q  <= skid_q;
            state_q <= S_ONE;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  tree_match_popcount #(
    .LANES (LANES),
    .CW    (PC_W)
  ) u_popcount (
    .bits_i  (dv_out_s & main_q.matched),
    .count_o (pop_s)
  );

  // Saturating counter update; a clear wins over the delivery in the same cycle
  always_comb begin
    sum_s = SUM_W'(count_q) + SUM_W'(pop_s);
    if (bus.clr_count) begin
      count_d = '0;
    end else if (out_fire_s) begin
      if (sum_s > CNT_MAX) begin
        count_d = '1;
      end else begin
        count_d = sum_s[COUNT_WIDTH-1:0];
      end
    end else begin
      count_d = count_q;
    end
  end

  // Match counter register, untouched by flush
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.in_ready       = in_ready_s;
  assign bus.out_valid      = out_valid_s;
  assign bus.packet_out     = main_q.packet;
  assign bus.node_out       = main_q.node;
  assign bus.matched_out    = main_q.matched;
  assign bus.data_valid_out = dv_out_s;
  assign bus.match_count    = count_q;

endmodule

// File: tb/tb_tree_stage_reg.sv
// Bench for tree_stage_reg: a 2-lane instance checked against a FIFO-of-two model,
// and a 4-lane instance with a 2-bit counter for empty bundles and saturation.
module tb_tree_stage_reg;

  logic clk;
  logic RSTn;
  int   n_cmp;
  int   n_err;

  tree_stage_reg_if #(.LANES(2), .PACKET_WIDTH(104), .NODE_WIDTH(40), .COUNT_WIDTH(32)) ifa ();
  tree_stage_reg_if #(.LANES(4), .PACKET_WIDTH(104), .NODE_WIDTH(40), .COUNT_WIDTH(2))  ifb ();

  tree_stage_reg #(.LANES(2), .PACKET_WIDTH(104), .NODE_WIDTH(40), .COUNT_WIDTH(32)) dut_a (
    .clk(clk), .RSTn(RSTn), .bus(ifa));
  tree_stage_reg #(.LANES(4), .PACKET_WIDTH(104), .NODE_WIDTH(40), .COUNT_WIDTH(2)) dut_b (
    .clk(clk), .RSTn(RSTn), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [207:0] p;
    logic [79:0]  n;
    logic [1:0]   m;
    logic [1:0]   v;
  } bun_t;

  // Reference model: the stage is a FIFO holding at most two bundles
  bun_t            q[$];
  bun_t            last_b;
  longint unsigned mcount;
  logic [207:0]    got_q[$];

  function automatic bun_t rand_bun();
    bun_t b;
    b = '0;
    for (int k = 0; k < 7; k++) b.p = {b.p[175:0], 32'($urandom)};
    for (int k = 0; k < 3; k++) b.n = {b.n[47:0], 32'($urandom)};
    b.m = 2'($urandom);
    b.v = 2'($urandom);
    return b;
  endfunction

  function automatic logic [35:0] exp_ctl();
    logic [1:0] v;
    v = 2'b00;
    if (q.size() > 0) v = q[0].v;
    return {(q.size() < 2), (q.size() > 0), v, mcount[31:0]};
  endfunction

  task automatic model_reset();
    q.delete();
    last_b = '0;
    mcount = 0;
  endtask

  task automatic drive_a(input bun_t b, input bit iv);
    ifa.packet_in     = b.p;
    ifa.node_in       = b.n;
    ifa.matched_in    = b.m;
    ifa.data_valid_in = b.v;
    ifa.in_valid      = iv;
  endtask

  task automatic step_a();
    bun_t cur;
    bit   inf, outf, fl, cl;
    cur  = '{p: ifa.packet_in, n: ifa.node_in, m: ifa.matched_in, v: ifa.data_valid_in};
    inf  = ifa.in_valid && (q.size() < 2);
    outf = ifa.out_ready && (q.size() > 0);
    fl   = ifa.flush;
    cl   = ifa.clr_count;
    if (ifa.out_valid && ifa.out_ready) got_q.push_back(ifa.packet_out);
    @(posedge clk);
    if (cl) begin
      mcount = 0;
    end else if (outf) begin
      mcount = mcount + 64'($countones(q[0].v & q[0].m));
      if (mcount > 64'hFFFF_FFFF) mcount = 64'hFFFF_FFFF;
    end
    if (fl) begin
      q.delete();
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(cur);
    end
    if (q.size() > 0) last_b = q[0];
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_cmp++;
    if ({ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count} !== exp_ctl()) begin
      n_err++;
      $display("FAIL reset_ctl got=%h exp=%h", {ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count}, exp_ctl());
    end
    n_cmp++;
    if ({ifa.packet_out, ifa.node_out, ifa.matched_out} !== {last_b.p, last_b.n, last_b.m}) begin
      n_err++;
      $display("FAIL reset_data got=%h exp=0", {ifa.packet_out, ifa.node_out, ifa.matched_out});
    end
    RSTn = 1'b1;
  endtask

  task automatic test_stream();
    ifa.out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      drive_a(rand_bun(), c < 4);
      step_a();
      n_cmp++;
      if ({ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count} !== exp_ctl()) begin
        n_err++;
        $display("FAIL stream_ctl cyc=%0d got=%h exp=%h", c, {ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count}, exp_ctl());
      end
      n_cmp++;
      if ({ifa.packet_out, ifa.node_out, ifa.matched_out} !== {last_b.p, last_b.n, last_b.m}) begin
        n_err++;
        $display("FAIL stream_data cyc=%0d got=%h exp=%h", c, ifa.packet_out, last_b.p);
      end
    end
  endtask

  task automatic test_stall();
    bun_t pend[3];
    int   idx;
    bit   acc;
    idx = 0;
    for (int k = 0; k < 3; k++) pend[k] = rand_bun();
    got_q.delete();
    ifa.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) ifa.out_ready = 1'b1;
      if (idx < 3) drive_a(pend[idx], 1'b1);
      else ifa.in_valid = 1'b0;
      acc = ifa.in_valid && ifa.in_ready;
      step_a();
      if (acc) idx++;
      n_cmp++;
      if ({ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count} !== exp_ctl()) begin
        n_err++;
        $display("FAIL stall_ctl cyc=%0d got=%h exp=%h", c, {ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count}, exp_ctl());
      end
      if (c == 1) begin
        n_cmp++;
        if (ifa.in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL stall_full in_ready=%b exp=0", ifa.in_ready);
        end
      end
    end
    n_cmp++;
    if (got_q.size() != 3) begin
      n_err++;
      $display("FAIL stall_count delivered=%0d exp=3", got_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (got_q[k] !== pend[k].p) begin
          n_err++;
          $display("FAIL stall_order idx=%0d got=%h exp=%h", k, got_q[k], pend[k].p);
        end
      end
    end
  endtask

  task automatic test_counter();
    bun_t b;
    ifa.out_ready = 1'b1;
    ifa.in_valid  = 1'b0;
    ifa.clr_count = 1'b1;
    step_a();
    ifa.clr_count = 1'b0;
    b = rand_bun(); b.v = 2'b11; b.m = 2'b01; drive_a(b, 1'b1); step_a();
    b = rand_bun(); b.v = 2'b10; b.m = 2'b10; drive_a(b, 1'b1); step_a();
    ifa.in_valid = 1'b0;
    step_a();
    step_a();
    n_cmp++;
    if (ifa.match_count !== 32'd2 || mcount != 64'd2) begin
      n_err++;
      $display("FAIL counter_sum got=%0d exp=2 model=%0d", ifa.match_count, mcount);
    end
    b = rand_bun(); b.v = 2'b11; b.m = 2'b11; drive_a(b, 1'b1); step_a();
    ifa.in_valid  = 1'b0;
    ifa.clr_count = 1'b1;
    step_a();
    ifa.clr_count = 1'b0;
    n_cmp++;
    if (ifa.match_count !== 32'd0 || ifa.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL counter_clr got=%0d out_valid=%b exp=0/0", ifa.match_count, ifa.out_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] c_before;
    ifa.out_ready = 1'b0;
    drive_a(rand_bun(), 1'b1); step_a();
    drive_a(rand_bun(), 1'b1); step_a();
    n_cmp++;
    if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_fill in_ready=%b out_valid=%b exp=0/1", ifa.in_ready, ifa.out_valid);
    end
    c_before = mcount[31:0];
    drive_a(rand_bun(), 1'b1);
    ifa.flush = 1'b1;
    step_a();
    ifa.flush    = 1'b0;
    ifa.in_valid = 1'b0;
    n_cmp++;
    if ({ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count} !== {1'b1, 1'b0, 2'b00, c_before}) begin
      n_err++;
      $display("FAIL flush_state got=%h exp=%h", {ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count}, {1'b1, 1'b0, 2'b00, c_before});
    end
    ifa.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step_a();
      n_cmp++;
      if ({ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count} !== exp_ctl()) begin
        n_err++;
        $display("FAIL flush_after cyc=%0d got=%h exp=%h", c, {ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count}, exp_ctl());
      end
      n_cmp++;
      if (ifa.packet_out !== last_b.p) begin
        n_err++;
        $display("FAIL flush_hold got=%h exp=%h", ifa.packet_out, last_b.p);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 80; c++) begin
      drive_a(rand_bun(), $urandom_range(0, 9) < 7);
      ifa.out_ready = ($urandom_range(0, 9) < 7);
      ifa.flush     = ($urandom_range(0, 15) == 0);
      ifa.clr_count = ($urandom_range(0, 15) == 0);
      step_a();
      n_cmp++;
      if ({ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count} !== exp_ctl()) begin
        n_err++;
        $display("FAIL random_ctl cyc=%0d got=%h exp=%h", c, {ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count}, exp_ctl());
      end
      n_cmp++;
      if ({ifa.packet_out, ifa.node_out, ifa.matched_out} !== {last_b.p, last_b.n, last_b.m}) begin
        n_err++;
        $display("FAIL random_data cyc=%0d got=%h exp=%h", c, ifa.packet_out, last_b.p);
      end
    end
    ifa.flush     = 1'b0;
    ifa.clr_count = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    step_a();
    step_a();
  endtask

  task automatic test_async_reset();
    bun_t b;
    ifa.out_ready = 1'b0;
    drive_a(rand_bun(), 1'b1); step_a();
    drive_a(rand_bun(), 1'b1); step_a();
    ifa.in_valid = 1'b0;
    #2;
    RSTn = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count} !== {1'b1, 1'b0, 2'b00, 32'd0}) begin
      n_err++;
      $display("FAIL areset_ctl got=%h exp=%h", {ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count}, {1'b1, 1'b0, 2'b00, 32'd0});
    end
    n_cmp++;
    if ({ifa.packet_out, ifa.node_out, ifa.matched_out} !== 290'd0) begin
      n_err++;
      $display("FAIL areset_data got=%h exp=0", {ifa.packet_out, ifa.node_out, ifa.matched_out});
    end
    @(posedge clk); #1;
    RSTn = 1'b1;
    b = rand_bun();
    drive_a(b, 1'b1);
    ifa.out_ready = 1'b1;
    step_a();
    ifa.in_valid = 1'b0;
    n_cmp++;
    if (ifa.out_valid !== 1'b1 || ifa.packet_out !== b.p || ifa.data_valid_out !== b.v) begin
      n_err++;
      $display("FAIL areset_first out_valid=%b got=%h exp=%h", ifa.out_valid, ifa.packet_out, b.p);
    end
    step_a();
    n_cmp++;
    if ({ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count} !== exp_ctl()) begin
      n_err++;
      $display("FAIL areset_drain got=%h exp=%h", {ifa.in_ready, ifa.out_valid, ifa.data_valid_out, ifa.match_count}, exp_ctl());
    end
  endtask

  task automatic test_lanes4();
    logic [3:0]   tv [5];
    logic [3:0]   tm [5];
    logic [415:0] pk;
    logic [415:0] pk_prev;
    int           exp_cnt;
    tv = '{4'b0000, 4'b1111, 4'b1111, 4'b0101, 4'b1111};
    tm = '{4'b1111, 4'b0011, 4'b1111, 4'b0101, 4'b1111};
    exp_cnt = 0;
    pk = '0;
    ifb.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pk_prev = pk;
      for (int k = 0; k < 13; k++) pk = {pk[383:0], 32'($urandom)};
      ifb.packet_in     = pk;
      ifb.in_valid      = (i < 5);
      ifb.clr_count     = (i == 5);
      ifb.data_valid_in = (i < 5) ? tv[i] : 4'b0000;
      ifb.matched_in    = (i < 5) ? tm[i] : 4'b0000;
      @(posedge clk); #1;
      if (i == 5) exp_cnt = 0;
      else if (i > 0) begin
        exp_cnt = exp_cnt + $countones(tv[i-1] & tm[i-1]);
        if (exp_cnt > 3) exp_cnt = 3;
      end
      n_cmp++;
      if ({ifb.out_valid, ifb.data_valid_out, ifb.match_count} !==
          {(i < 5), ((i < 5) ? tv[i] : 4'b0000), 2'(exp_cnt)}) begin
        n_err++;
        $display("FAIL lanes4 step=%0d got=%h exp=%h", i, {ifb.out_valid, ifb.data_valid_out, ifb.match_count},
                 {(i < 5), ((i < 5) ? tv[i] : 4'b0000), 2'(exp_cnt)});
      end
      if (i < 5) begin
        n_cmp++;
        if (ifb.packet_out !== pk) begin
          n_err++;
          $display("FAIL lanes4_data step=%0d got=%h exp=%h", i, ifb.packet_out, pk);
        end
      end else begin
        n_cmp++;
        if (ifb.packet_out !== pk_prev) begin
          n_err++;
          $display("FAIL lanes4_hold got=%h exp=%h", ifb.packet_out, pk_prev);
        end
      end
    end
    ifb.clr_count = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    RSTn  = 1'b0;
    model_reset();
    drive_a('0, 1'b0);
    ifa.out_ready = 1'b0;
    ifa.flush     = 1'b0;
    ifa.clr_count = 1'b0;
    ifb.packet_in     = '0;
    ifb.node_in       = '0;
    ifb.matched_in    = '0;
    ifb.data_valid_in = '0;
    ifb.in_valid      = 1'b0;
    ifb.out_ready     = 1'b0;
    ifb.flush         = 1'b0;
    ifb.clr_count     = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_counter();
    test_flush();
    test_random();
    test_async_reset();
    test_lanes4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tree_stage_reg.md
# tree_stage_reg

Parametrised, elastic pipeline register between two levels of the classification tree. It carries LANES parallel packet/node/matched/valid lanes as one bundle and adds a valid/ready handshake with a 2-entry skid buffer, so a downstream stall never drops a bundle. It also adds a synchronous flush and a saturating matched-lane counter. It replaces the fixed two-lane, always-advancing stage registers between tree levels.

## Interface
- LANES, 2, number of parallel packet lanes per bundle (≥1)
- PACKET_WIDTH, 104, packet header width per lane
- NODE_WIDTH, 40, tree node width per lane
- COUNT_WIDTH, 32, width of match_count
- clk  input  1  clock; all logic on posedge
- RSTn  input  1  reset, asynchronous, active-low
- packet_in  input  LANES*PACKET_WIDTH  lane i at bits [i*PACKET_WIDTH +: PACKET_WIDTH]
- node_in  input  LANES*NODE_WIDTH  lane i at [i*NODE_WIDTH +: NODE_WIDTH]
- matched_in  input  LANES  per-lane matched flag
- data_valid_in  input  LANES  per-lane slot occupancy within the bundle
- in_valid  input  1  upstream offers a bundle
- in_ready  output  1  stage can accept a bundle
- packet_out, node_out, matched_out, data_valid_out  output  same widths as inputs  bundle at head of stage
- out_valid  output  1  head bundle valid
- out_ready  input  1  downstream accepts head bundle
- flush  input  1  synchronous discard of all held bundles
- clr_count  input  1  synchronous clear of match_count
- match_count  output  COUNT_WIDTH  saturating count of matched, valid lanes delivered

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- A bundle with in_valid=1 and data_valid_in=0 is accepted and delivered like any other bundle. Per-lane bits pass through unchanged.
- Storage: main register (drives outputs) and skid register. States: EMPTY, ONE, TWO.
  - EMPTY: in_fire → load main, ONE.
  - ONE: in_fire & !out_fire → load skid, TWO. in_fire & out_fire → load main, stay ONE. out_fire only → EMPTY.
  - TWO: no in_fire possible. out_fire → main ← skid, ONE.
- in_ready = (state != TWO). out_valid = (state != EMPTY). Both are decoded from the state register only; there is no combinational in→out path.
- data_valid_out = main lane-valid bits gated by out_valid, so it is 0 when EMPTY. packet_out, node_out and matched_out hold their last value when EMPTY.
- flush has priority over all other events. Next state is EMPTY, and any in_fire in the flush cycle is discarded. match_count is not affected by flush.
- match_count: on out_fire, add popcount(data_valid_out & matched_out), saturating at 2^COUNT_WIDTH-1. clr_count has priority: in the clear cycle match_count ← 0 and that cycle's increment is dropped. flush & out_fire in the same cycle still counts the delivered bundle.
- Reset values:
  - state EMPTY, in_ready=1, out_valid=0.
  - packet_out, node_out, matched_out, data_valid_out = 0.
  - skid contents = 0, match_count = 0.

## Timing
- Latency 1 cycle: a bundle accepted at edge N is on the outputs with out_valid=1 after edge N.
- Throughput 1 bundle/cycle while out_ready=1.
- in_ready falls the cycle after the second bundle is taken while stalled. At most 2 bundles are held.
- Ordering is strictly FIFO; skid contents always leave before later input.
- Asserting RSTn low mid-transfer clears everything immediately. The first bundle can be accepted on the first posedge after RSTn rises.

## Structure
- Shared package tree_pipe_pkg:
  - state encoding localparams ST_EMPTY/ST_ONE/ST_TWO (2 bits)
  - default PACKET_WIDTH/NODE_WIDTH constants, shared with the tree node stages
- Sub-module tree_match_popcount: LANES-input popcount, output width $clog2(LANES+1), combinational.
- Everything else (state machine, main/skid registers, counter) lives in tree_stage_reg.

## Test plan
- Reset then stream, LANES=2, out_ready=1: 4 bundles on consecutive cycles → each appears 1 cycle later in order, in_ready stays 1, no bubbles.
- Stall: out_ready=0, offer bundles A,B,C → A,B accepted, in_ready=0 after B, C held upstream. Release out_ready → A,B,C delivered in order, none lost or duplicated.
- Counter: lanes valid=2'b11 matched=2'b01, then valid=2'b10 matched=2'b10 → match_count=2. With COUNT_WIDTH=2 preloaded to 3, a further matched delivery keeps it at 3. clr_count together with out_fire → 0.
- Flush in TWO with in_valid=1 → next cycle out_valid=0, in_ready=1, data_valid_out=0, the offered bundle is discarded, match_count is unchanged.
- Async reset mid-stall (state TWO) → outputs go to reset values without a clock edge. After release, one bundle passes with 1-cycle latency.
- LANES=4, data_valid_in=4'b0000, in_valid=1 → bundle delivered with out_valid=1, data_valid_out=0, match_count unchanged.
